// File: rtl/fault_map_writer.sv
// rtl/fault_map_writer.sv - SA/TD scan fault map collector and eNVM fault-storage writer
module fault_map_writer #(
    parameter int SYSTOLIC_SIZE       = 8,
    parameter int ADDR_WIDTH          = $clog2(SYSTOLIC_SIZE),
    parameter int ROW_FAULT_THRESHOLD = 2,
    parameter int COL_FAULT_THRESHOLD = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clear,
    input  logic                     mismatch_valid,
    input  logic [ADDR_WIDTH-1:0]    mismatch_row,
    input  logic [SYSTOLIC_SIZE-1:0] mismatch_vec,
    input  logic                     commit,
    output logic                     busy,
    output logic                     done,
    output logic                     detection_en,
    output logic [ADDR_WIDTH-1:0]    detection_addr,
    output logic [SYSTOLIC_SIZE-1:0] single_pe_detection,
    output logic [SYSTOLIC_SIZE-1:0] column_fault_detection,
    output logic [SYSTOLIC_SIZE-1:0] row_fault_detection
);

    // Popcount of up to SYSTOLIC_SIZE ones needs one bit more than the address
    localparam int CNT_W = $clog2(SYSTOLIC_SIZE) + 1;
    localparam logic [CNT_W-1:0]      ROW_THR  = CNT_W'(ROW_FAULT_THRESHOLD);
    localparam logic [CNT_W-1:0]      COL_THR  = CNT_W'(COL_FAULT_THRESHOLD);
    localparam logic [ADDR_WIDTH-1:0] LAST_ROW = ADDR_WIDTH'(SYSTOLIC_SIZE - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t                  state;
    logic [ADDR_WIDTH-1:0]   counter;
    logic [SYSTOLIC_SIZE-1:0] map [SYSTOLIC_SIZE];

    logic [CNT_W-1:0]         row_cnt [SYSTOLIC_SIZE];
    logic [CNT_W-1:0]         col_cnt [SYSTOLIC_SIZE];
    logic [SYSTOLIC_SIZE-1:0] row_fault;
    logic [SYSTOLIC_SIZE-1:0] col_fault;

    // Sticky fault map: accumulates mismatches only while idle so a write sees a frozen map
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < SYSTOLIC_SIZE; i++) begin
                map[i] <= '0;
            end
        end else if (clear) begin
            for (int i = 0; i < SYSTOLIC_SIZE; i++) begin
                map[i] <= '0;
            end
        end else if (state == ST_IDLE && mismatch_valid) begin
            map[mismatch_row] <= map[mismatch_row] | mismatch_vec;
        end
    end

    // Write sequencer: one eNVM row per cycle, then a single done pulse
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= ST_IDLE;
            counter      <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            detection_en <= 1'b0;
        end else if (clear) begin
            // Abort silently: no done pulse for an interrupted write
            state        <= ST_IDLE;
            counter      <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            detection_en <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    done <= 1'b0;
                    if (commit) begin
                        state        <= ST_WRITE;
                        counter      <= '0;
                        busy         <= 1'b1;
                        detection_en <= 1'b1;
                    end
                end
                ST_WRITE: begin
                    if (counter == LAST_ROW) begin
                        // Stop at the last row instead of wrapping
                        state        <= ST_DONE;
                        counter      <= '0;
                        detection_en <= 1'b0;
                        done         <= 1'b1;
                    end else begin
                        counter <= counter + ADDR_WIDTH'(1);
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                    done  <= 1'b0;
                    busy  <= 1'b0;
                end
                default: begin
                    state        <= ST_IDLE;
                    counter      <= '0;
                    busy         <= 1'b0;
                    done         <= 1'b0;
                    detection_en <= 1'b0;
                end
            endcase
        end
    end

    // Per-row and per-column faulty-PE counts taken straight from the map register
    always_comb begin
        for (int r = 0; r < SYSTOLIC_SIZE; r++) begin
            row_cnt[r] = '0;
            col_cnt[r] = '0;
        end
        for (int r = 0; r < SYSTOLIC_SIZE; r++) begin
            for (int c = 0; c < SYSTOLIC_SIZE; c++) begin
                row_cnt[r] = row_cnt[r] + CNT_W'(map[r][c]);
                col_cnt[c] = col_cnt[c] + CNT_W'(map[r][c]);
            end
        end
    end

    // Threshold the counts into whole-row and whole-column fault flags
    always_comb begin
        row_fault = '0;
        col_fault = '0;
        for (int i = 0; i < SYSTOLIC_SIZE; i++) begin
            row_fault[i] = (row_cnt[i] >= ROW_THR);
            col_fault[i] = (col_cnt[i] >= COL_THR);
        end
    end

    assign detection_addr = counter;

    // Isolated PEs are those not already covered by a row or column fault
    always_comb begin
        single_pe_detection    = map[detection_addr] & ~col_fault
                                 & {SYSTOLIC_SIZE{~row_fault[detection_addr]}};
        row_fault_detection    = detection_en ? row_fault : '0;
        column_fault_detection = detection_en ? col_fault : '0;
    end

endmodule

// File: tb/tb_fault_map_writer.sv
// tb/tb_fault_map_writer.sv - scoreboard bench for fault_map_writer
module tb_fault_map_writer;

    localparam int N  = 8;
    localparam int AW = 3;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [N-1:0]  single;
        logic [N-1:0]  col;
        logic [N-1:0]  row;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          clear;
    logic          mismatch_valid;
    logic [AW-1:0] mismatch_row;
    logic [N-1:0]  mismatch_vec;
    logic          commit;
    logic          busy;
    logic          done;
    logic          detection_en;
    logic [AW-1:0] detection_addr;
    logic [N-1:0]  single_pe_detection;
    logic [N-1:0]  column_fault_detection;
    logic [N-1:0]  row_fault_detection;

    logic [N-1:0]  model [N];
    exp_t          sb [$];
    exp_t          mon_e;
    int            n_cmp = 0;
    int            n_err = 0;

    fault_map_writer #(
        .SYSTOLIC_SIZE(N),
        .ADDR_WIDTH(AW),
        .ROW_FAULT_THRESHOLD(2),
        .COL_FAULT_THRESHOLD(2)
    ) dut (
        .clk(clk),
        .rst(rst),
        .clear(clear),
        .mismatch_valid(mismatch_valid),
        .mismatch_row(mismatch_row),
        .mismatch_vec(mismatch_vec),
        .commit(commit),
        .busy(busy),
        .done(done),
        .detection_en(detection_en),
        .detection_addr(detection_addr),
        .single_pe_detection(single_pe_detection),
        .column_fault_detection(column_fault_detection),
        .row_fault_detection(row_fault_detection)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_zero();
        for (int r = 0; r < N; r++) model[r] = '0;
    endtask

    // Build the eight expected write beats from the bench's own copy of the map
    task automatic push_expected();
        logic [N-1:0] rf;
        logic [N-1:0] cf;
        int           cnt;
        exp_t         e;
        rf = '0;
        cf = '0;
        for (int r = 0; r < N; r++) rf[r] = ($countones(model[r]) >= 2);
        for (int c = 0; c < N; c++) begin
            cnt = 0;
            for (int r = 0; r < N; r++) if (model[r][c]) cnt++;
            cf[c] = (cnt >= 2);
        end
        for (int r = 0; r < N; r++) begin
            e.addr   = AW'(r);
            e.single = rf[r] ? '0 : (model[r] & ~cf);
            e.col    = cf;
            e.row    = rf;
            sb.push_back(e);
        end
    endtask

    task automatic drive_mismatch(input logic [AW-1:0] r, input logic [N-1:0] v);
        mismatch_valid = 1'b1;
        mismatch_row   = r;
        mismatch_vec   = v;
        model[r]       = model[r] | v;
        @(negedge clk);
        mismatch_valid = 1'b0;
        mismatch_vec   = '0;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        model_zero();
        @(negedge clk);
        clear = 1'b0;
    endtask

    task automatic start_commit(input bit with_mm, input logic [AW-1:0] r, input logic [N-1:0] v);
        commit = 1'b1;
        if (with_mm) begin
            mismatch_valid = 1'b1;
            mismatch_row   = r;
            mismatch_vec   = v;
            model[r]       = model[r] | v;
        end
        push_expected();
        @(negedge clk);
        commit         = 1'b0;
        mismatch_valid = 1'b0;
        mismatch_vec   = '0;
    endtask

    // Cycle k counts from the first cycle after the commit edge
    task automatic finish_commit(input int inject_at);
        for (int k = 1; k <= N + 2; k++) begin
            check($sformatf("busy_k%0d", k), busy, (k <= N + 1));
            check($sformatf("done_k%0d", k), done, (k == N + 1));
            check($sformatf("en_k%0d", k), detection_en, (k <= N));
            if (k == inject_at) begin
                mismatch_valid = 1'b1;
                mismatch_row   = 3'd2;
                mismatch_vec   = 8'hFF;
                commit         = 1'b1;
            end else if (k == inject_at + 1) begin
                mismatch_valid = 1'b0;
                mismatch_vec   = '0;
                commit         = 1'b0;
            end
            @(negedge clk);
        end
        check("sb_drained", sb.size(), 0);
    endtask

    task automatic wait_addr(input logic [AW-1:0] a);
        for (int i = 0; i < 20; i++) begin
            if (detection_en && detection_addr == a) break;
            @(negedge clk);
        end
        check("reach_addr", {detection_en, detection_addr}, {1'b1, a});
    endtask

    // Scoreboard consumer: every write beat must match the next expected row
    always @(negedge clk) begin
        if (!rst && detection_en) begin
            if (sb.size() == 0) begin
                check("unexpected_write", {31'b0, detection_en}, 32'd0);
            end else begin
                mon_e = sb.pop_front();
                check("addr", detection_addr, mon_e.addr);
                check($sformatf("single_a%0d", mon_e.addr), single_pe_detection, mon_e.single);
                check($sformatf("col_a%0d", mon_e.addr), column_fault_detection, mon_e.col);
                check($sformatf("row_a%0d", mon_e.addr), row_fault_detection, mon_e.row);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst            = 1'b1;
        clear          = 1'b0;
        mismatch_valid = 1'b0;
        mismatch_row   = '0;
        mismatch_vec   = '0;
        commit         = 1'b0;
        model_zero();
        repeat (2) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_en", detection_en, 0);
        check("rst_addr", detection_addr, 0);
        check("rst_single", single_pe_detection, 0);
        check("rst_col", column_fault_detection, 0);
        check("rst_row", row_fault_detection, 0);
        rst = 1'b0;
        @(negedge clk);

        // Empty map
        start_commit(0, '0, '0);
        finish_commit(0);

        // Isolated single PE
        drive_mismatch(3'd3, 8'h10);
        start_commit(0, '0, '0);
        finish_commit(0);
        do_clear();

        // Row fault
        drive_mismatch(3'd5, 8'h06);
        start_commit(0, '0, '0);
        finish_commit(0);
        do_clear();

        // Column fault (row 6 also reaches the row threshold)
        drive_mismatch(3'd1, 8'h01);
        drive_mismatch(3'd6, 8'h81);
        start_commit(0, '0, '0);
        finish_commit(0);
        do_clear();

        // Clear in the middle of a write
        drive_mismatch(3'd2, 8'h3C);
        start_commit(0, '0, '0);
        wait_addr(3'd4);
        clear = 1'b1;
        model_zero();
        @(negedge clk);
        clear = 1'b0;
        check("clr_en", detection_en, 0);
        check("clr_busy", busy, 0);
        check("clr_done", done, 0);
        check("clr_left", sb.size(), 3);
        sb.delete();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("clr_no_done", done, 0);
            check("clr_idle", busy, 0);
        end
        start_commit(0, '0, '0);
        finish_commit(0);

        // Mismatch and commit during WRITE are ignored
        drive_mismatch(3'd4, 8'h08);
        start_commit(0, '0, '0);
        finish_commit(3);
        // Mismatch merged in the commit cycle; row 4 rewritten unchanged
        start_commit(1, 3'd0, 8'h01);
        finish_commit(0);
        do_clear();

        // Asynchronous reset between clock edges during a write
        drive_mismatch(3'd7, 8'h01);
        start_commit(0, '0, '0);
        wait_addr(3'd2);
        #2;
        rst = 1'b1;
        #1;
        check("arst_busy", busy, 0);
        check("arst_done", done, 0);
        check("arst_en", detection_en, 0);
        check("arst_addr", detection_addr, 0);
        check("arst_single", single_pe_detection, 0);
        check("arst_col", column_fault_detection, 0);
        check("arst_row", row_fault_detection, 0);
        check("arst_left", sb.size(), 5);
        sb.delete();
        model_zero();
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        start_commit(0, '0, '0);
        finish_commit(0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
